// File: rtl/minirv_pkg.sv
// ---------------------------------------------------------------------------
// minirv_pkg
// Shared definitions for the miniRV control sequencer:
//   - state_t     : control FSM state encodings (also exported on `state`)
//   - WB_*        : register-file writeback source select codes
//   - CLS_*       : bit positions inside the one-hot instruction class vector
//   - BE_WORD     : byte-enable pattern for a full 32-bit access
//   - cls_valid() : true when the class vector names exactly one legal class
//   - lane_be()   : single-byte enable for a byte lane
// ---------------------------------------------------------------------------
package minirv_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam int CLS_W       = 9;
    localparam int CLS_ADD     = 0;
    localparam int CLS_ADDI    = 1;
    localparam int CLS_LUI     = 2;
    localparam int CLS_LW      = 3;
    localparam int CLS_LBU     = 4;
    localparam int CLS_SW      = 5;
    localparam int CLS_SB      = 6;
    localparam int CLS_JALR    = 7;
    localparam int CLS_ILLEGAL = 8;

    localparam logic [3:0] BE_WORD = 4'b1111;

    // Exactly one class bit set, and that bit is not the illegal marker.
    function automatic logic cls_valid(input logic [CLS_W-1:0] cls);
        logic [3:0] ones;
        ones = 4'd0;
        for (int i = 0; i < CLS_W; i++) begin
            ones = ones + {3'd0, cls[i]};
        end
        return (ones == 4'd1) && !cls[CLS_ILLEGAL];
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] lo);
        return 4'b0001 << lo;
    endfunction

endpackage

// File: rtl/minirv_mem_wait.sv
// ---------------------------------------------------------------------------
// minirv_mem_wait
// Request/ready handshake for one memory port, with a bounded wait.
// The request register rises on i_start and falls when ready is sampled or
// when the wait budget runs out.
//
// Ports:
//   clk       in   core clock, rising edge
//   rst       in   asynchronous active-low reset
//   i_start   in   open a new request (clears the wait counter)
//   i_ready   in   memory side ready; ignored while no request is open
//   o_req     out  registered request to memory
//   o_done    out  handshake completes this cycle (req & ready)
//   o_timeout out  this is the MEM_TIMEOUT-th cycle waited without ready
// ---------------------------------------------------------------------------
module minirv_mem_wait #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_ready,
    output logic o_req,
    output logic o_done,
    output logic o_timeout
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    logic            r_req;
    logic [TO_W-1:0] r_cnt;

    assign o_req  = r_req;
    assign o_done = r_req & i_ready;
    // Flag the cycle in which the counter would reach MEM_TIMEOUT, so the
    // owner leaves on this edge and the request is gone the next cycle.
    assign o_timeout = r_req & ~i_ready & (r_cnt == TO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_req <= 1'b1;
            r_cnt <= '0;
        end else if (r_req) begin
            if (i_ready || o_timeout) begin
                r_req <= 1'b0;
            end
            if (!i_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/minirv_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// minirv_ctrl_fsm
// Multi-cycle control sequencer for the miniRV core:
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with a sticky TRAP for
// illegal/ambiguous classes, misaligned word accesses and memory timeouts.
//
// Optional feature (macro MINIRV_CTRL_PERF_EN): adds perf_cycles (cycles
// spent outside TRAP) and perf_instret (number of pc_we pulses), both 32-bit
// wrapping counters.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   instr_onehot    one-hot class [0]add [1]addi [2]lui [3]lw [4]lbu
//                   [5]sw [6]sb [7]jalr [8]illegal
//   addr_lo         ALU result [1:0], byte lane for byte accesses
//   imem_req/ready  instruction fetch handshake
//   dmem_req/ready  data memory handshake; dmem_we/dmem_be qualify it
//   ir_we           latch instruction register (fetch handshake cycle)
//   alu_src_imm     ALU operand B = immediate
//   wb_sel          writeback source (WB_ALU/WB_MEM/WB_PC4/WB_IMM)
//   reg_we, pc_we   register file / PC write enables
//   pc_sel          PC source, 1 = jalr target
//   trap            sticky fault flag
//   state           current state encoding
// ---------------------------------------------------------------------------
module minirv_ctrl_fsm
    import minirv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CLS_W-1:0] instr_onehot,
    input  logic [1:0]       addr_lo,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [3:0]       dmem_be,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             alu_src_imm,
    output logic [1:0]       wb_sel,
    output logic             reg_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             trap,
    output logic [2:0]       state
`ifdef MINIRV_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_instret
`endif
);

    state_t     r_state;
    logic       r_alu_src_imm;
    logic [1:0] r_wb_sel;
    logic       r_reg_we;
    logic       r_pc_we_wb;
    logic       r_pc_sel;
    logic       r_dmem_we;
    logic [3:0] r_dmem_be;
    logic       r_trap;

    logic w_imem_req, w_if_done, w_if_timeout, w_if_start;
    logic w_dmem_req, w_dm_done, w_dm_timeout, w_dm_start;
    logic w_is_load, w_is_store, w_is_mem, w_is_word, w_misaligned;
    logic [3:0] w_be;
    logic [1:0] w_wb_sel;
    logic w_pc_we;

    // The classifier decodes the instruction register, which only changes on
    // ir_we, so instr_onehot is stable from DECODE until the next fetch.
    assign w_is_load    = instr_onehot[CLS_LW] | instr_onehot[CLS_LBU];
    assign w_is_store   = instr_onehot[CLS_SW] | instr_onehot[CLS_SB];
    assign w_is_mem     = w_is_load | w_is_store;
    assign w_is_word    = instr_onehot[CLS_LW] | instr_onehot[CLS_SW];
    assign w_misaligned = w_is_word && (addr_lo != 2'b00);
    assign w_be         = w_is_word ? BE_WORD : lane_be(addr_lo);

    always_comb begin
        w_wb_sel = WB_ALU;
        if (instr_onehot[CLS_JALR]) begin
            w_wb_sel = WB_PC4;
        end else if (instr_onehot[CLS_LUI]) begin
            w_wb_sel = WB_IMM;
        end
    end

    // Fetch opens on every entry to FETCH; the FETCH-without-request case only
    // occurs in the first cycle after reset.
    assign w_if_start = (r_state == ST_WB)
                     || ((r_state == ST_MEM) && w_dm_done && r_dmem_we)
                     || ((r_state == ST_FETCH) && !w_imem_req);
    // A misaligned word access traps straight from EXEC and never requests.
    assign w_dm_start = (r_state == ST_EXEC) && w_is_mem && !w_misaligned;

    minirv_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_imem_wait (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_if_start),
        .i_ready   (imem_ready),
        .o_req     (w_imem_req),
        .o_done    (w_if_done),
        .o_timeout (w_if_timeout)
    );

    minirv_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_dmem_wait (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_dm_start),
        .i_ready   (dmem_ready),
        .o_req     (w_dmem_req),
        .o_done    (w_dm_done),
        .o_timeout (w_dm_timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_FETCH;
            r_alu_src_imm <= 1'b0;
            r_wb_sel      <= WB_ALU;
            r_reg_we      <= 1'b0;
            r_pc_we_wb    <= 1'b0;
            r_pc_sel      <= 1'b0;
            r_dmem_we     <= 1'b0;
            r_dmem_be     <= 4'b0000;
            r_trap        <= 1'b0;
        end else begin
            // Writeback controls are single-cycle and only live in WB.
            r_reg_we   <= 1'b0;
            r_pc_we_wb <= 1'b0;
            r_pc_sel   <= 1'b0;
            r_wb_sel   <= WB_ALU;
            case (r_state)
                ST_FETCH: begin
                    if (w_if_timeout) begin
                        r_state <= ST_TRAP;
                        r_trap  <= 1'b1;
                    end else if (w_if_done) begin
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!cls_valid(instr_onehot)) begin
                        r_state <= ST_TRAP;
                        r_trap  <= 1'b1;
                    end else begin
                        r_state       <= ST_EXEC;
                        // Held through MEM/WB so the ALU result stays valid
                        // as the address and as the writeback value.
                        r_alu_src_imm <= !instr_onehot[CLS_ADD];
                    end
                end
                ST_EXEC: begin
                    if (w_is_mem) begin
                        if (w_misaligned) begin
                            r_state       <= ST_TRAP;
                            r_trap        <= 1'b1;
                            r_alu_src_imm <= 1'b0;
                        end else begin
                            r_state   <= ST_MEM;
                            r_dmem_we <= w_is_store;
                            r_dmem_be <= w_be;
                        end
                    end else begin
                        r_state    <= ST_WB;
                        r_reg_we   <= 1'b1;
                        r_pc_we_wb <= 1'b1;
                        r_wb_sel   <= w_wb_sel;
                        r_pc_sel   <= instr_onehot[CLS_JALR];
                    end
                end
                ST_MEM: begin
                    if (w_dm_timeout) begin
                        r_state       <= ST_TRAP;
                        r_trap        <= 1'b1;
                        r_alu_src_imm <= 1'b0;
                        r_dmem_we     <= 1'b0;
                        r_dmem_be     <= 4'b0000;
                    end else if (w_dm_done) begin
                        r_dmem_we <= 1'b0;
                        r_dmem_be <= 4'b0000;
                        if (r_dmem_we) begin
                            // Store retires here; pc_we pulses combinationally.
                            r_state       <= ST_FETCH;
                            r_alu_src_imm <= 1'b0;
                        end else begin
                            r_state    <= ST_WB;
                            r_reg_we   <= 1'b1;
                            r_pc_we_wb <= 1'b1;
                            r_wb_sel   <= WB_MEM;
                        end
                    end
                end
                ST_WB: begin
                    r_state       <= ST_FETCH;
                    r_alu_src_imm <= 1'b0;
                end
                ST_TRAP: begin
                    r_trap <= 1'b1;
                end
                default: begin
                    r_state       <= ST_TRAP;
                    r_trap        <= 1'b1;
                    r_alu_src_imm <= 1'b0;
                end
            endcase
        end
    end

    // Handshake-completion strobes are gated by the registered request, so
    // they vanish with it on reset and ignore ready while no request is open.
    assign w_pc_we     = r_pc_we_wb | (w_dm_done & r_dmem_we);

    assign imem_req    = w_imem_req;
    assign ir_we       = w_if_done;
    assign dmem_req    = w_dmem_req;
    assign dmem_we     = r_dmem_we;
    assign dmem_be     = r_dmem_be;
    assign alu_src_imm = r_alu_src_imm;
    assign wb_sel      = r_wb_sel;
    assign reg_we      = r_reg_we;
    assign pc_we       = w_pc_we;
    assign pc_sel      = r_pc_sel;
    assign trap        = r_trap;
    assign state       = r_state;

`ifdef MINIRV_CTRL_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_instret;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_cycles  <= 32'd0;
            r_perf_instret <= 32'd0;
        end else begin
            if (r_state != ST_TRAP) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (w_pc_we) begin
                r_perf_instret <= r_perf_instret + 32'd1;
            end
        end
    end

    assign perf_cycles  = r_perf_cycles;
    assign perf_instret = r_perf_instret;
`endif

endmodule

// File: tb/tb_minirv_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_minirv_ctrl_fsm
// Directed bench for the miniRV control sequencer. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_minirv_ctrl_fsm;

    localparam logic [8:0] OH_ADDI = 9'b000000010;
    localparam logic [8:0] OH_LW   = 9'b000001000;
    localparam logic [8:0] OH_LBU  = 9'b000010000;
    localparam logic [8:0] OH_SW   = 9'b000100000;
    localparam logic [8:0] OH_JALR = 9'b010000000;
    localparam logic [8:0] OH_TWO  = 9'b000001001;
    localparam logic [8:0] OH_ILL  = 9'h100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [8:0] instr_onehot = '0;
    logic [1:0] addr_lo = '0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_we, alu_src_imm;
    logic       reg_we, pc_we, pc_sel, trap;
    logic [3:0] dmem_be;
    logic [1:0] wb_sel;
    logic [2:0] state;
`ifdef MINIRV_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_instret;
`endif

    logic [17:0] outs;
    assign outs = {imem_req, dmem_req, dmem_we, dmem_be, ir_we, alu_src_imm,
                   wb_sel, reg_we, pc_we, pc_sel, trap, state};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t0, nreq, lat;
    logic seen_req, seen_notrap;

    minirv_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_onehot (instr_onehot),
        .addr_lo      (addr_lo),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_be      (dmem_be),
        .dmem_ready   (dmem_ready),
        .ir_we        (ir_we),
        .alu_src_imm  (alu_src_imm),
        .wb_sel       (wb_sel),
        .reg_we       (reg_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .trap         (trap),
        .state        (state)
`ifdef MINIRV_CTRL_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_instret (perf_instret)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s = %0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in a FETCH cycle with imem_req high; returns in DECODE.
    task automatic fetch(input logic [8:0] oh);
        instr_onehot = oh;
        imem_ready   = 1'b1;
        #1;
        chk("fetch_ir_we", 32'(ir_we), 32'd1);
        tick();
        imem_ready = 1'b0;
    endtask

    // Reset, release, and return in the first cycle with imem_req high.
    task automatic do_reset();
        rst = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // ---- reset state ----
        tick();
        tick();
        chk("reset_outs", 32'(outs), 32'd0);
`ifdef MINIRV_CTRL_PERF_EN
        chk("perf_instret_rst", perf_instret, 32'd0);
        chk("perf_cycles_rst", perf_cycles, 32'd0);
`endif
        // ---- release with a stray ready while no request is open ----
        rst = 1'b1;
        imem_ready = 1'b1;
        #1;
        chk("idle_ir_we", 32'(ir_we), 32'd0);
        tick();
        chk("idle_ready_ignored_state", 32'(state), 32'd0);
        chk("first_imem_req", 32'(imem_req), 32'd1);

        // ---- addi: 0->1->2->4->0 in 4 cycles ----
        t0 = cyc;
        fetch(OH_ADDI);
        chk("addi_decode_state", 32'(state), 32'd1);
        chk("addi_decode_imem_req", 32'(imem_req), 32'd0);
        tick();
        chk("addi_exec_state", 32'(state), 32'd2);
        chk("addi_exec_alu_imm", 32'(alu_src_imm), 32'd1);
        tick();
        chk("addi_wb_state", 32'(state), 32'd4);
        chk("addi_wb_ctl", 32'({reg_we, wb_sel, alu_src_imm, pc_we, pc_sel}), 32'b1_00_1_1_0);
        tick();
        chk("addi_next_state", 32'(state), 32'd0);
        chk("addi_latency", 32'(cyc - t0), 32'd4);

        // ---- lbu, lane 2, ready after 3 wait cycles ----
        addr_lo = 2'd2;
        t0 = cyc;
        fetch(OH_LBU);
        tick();
        chk("lbu_exec_state", 32'(state), 32'd2);
        tick();
        chk("lbu_mem_state", 32'(state), 32'd3);
        chk("lbu_be", 32'(dmem_be), 32'b0100);
        chk("lbu_we", 32'(dmem_we), 32'd0);
        nreq = 0;
        for (int i = 0; i < 3; i++) begin
            if (dmem_req) nreq++;
            tick();
        end
        dmem_ready = 1'b1;
        if (dmem_req) nreq++;
        tick();
        dmem_ready = 1'b0;
        chk("lbu_req_cycles", 32'(nreq), 32'd4);
        chk("lbu_wb_state", 32'(state), 32'd4);
        chk("lbu_wb_ctl", 32'({reg_we, pc_we, wb_sel, dmem_req}), 32'b1_1_01_0);
        tick();
        chk("lbu_latency", 32'(cyc - t0), 32'd8);

        // ---- jalr ----
        t0 = cyc;
        fetch(OH_JALR);
        tick();
        tick();
        chk("jalr_wb_ctl", 32'({wb_sel, pc_sel, reg_we, pc_we}), 32'b10_1_1_1);
        tick();
        chk("jalr_latency", 32'(cyc - t0), 32'd4);

        // ---- sw aligned: 4 cycles, pc_we on ready ----
        addr_lo = 2'd0;
        t0 = cyc;
        fetch(OH_SW);
        tick();
        tick();
        chk("sw_mem_ctl", 32'({dmem_req, dmem_we, dmem_be}), 32'b1_1_1111);
        dmem_ready = 1'b1;
        #1;
        chk("sw_pc_we", 32'({pc_we, pc_sel, reg_we}), 32'b1_0_0);
        tick();
        dmem_ready = 1'b0;
        chk("sw_after_state", 32'(state), 32'd0);
        chk("sw_after_dmem_req", 32'(dmem_req), 32'd0);
        chk("sw_latency", 32'(cyc - t0), 32'd4);

        // ---- lw interrupted by reset mid-MEM ----
        fetch(OH_LW);
        tick();
        tick();
        chk("lw_mem_ctl", 32'({dmem_req, dmem_we, dmem_be}), 32'b1_0_1111);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_mem_outs", 32'(outs), 32'd0);
        tick();
        rst = 1'b1;
        chk("post_reset_state", 32'(state), 32'd0);
        tick();

        // ---- sw misaligned: trap from EXEC, no request ----
        addr_lo = 2'd1;
        fetch(OH_SW);
        tick();
        tick();
        seen_req = 1'b0;
        seen_notrap = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dmem_req) seen_req = 1'b1;
            if (!trap) seen_notrap = 1'b1;
            tick();
        end
        chk("misalign_dmem_req_seen", 32'(seen_req), 32'd0);
        chk("misalign_trap_dropped", 32'(seen_notrap), 32'd0);
        chk("misalign_state", 32'(state), 32'd7);
        addr_lo = 2'd0;

        // ---- imem timeout ----
        do_reset();
        chk("to_first_req", 32'(imem_req), 32'd1);
        lat = 0;
        nreq = 0;
        for (int i = 0; i < 40; i++) begin
            if (trap) break;
            if (imem_req) nreq++;
            lat++;
            tick();
        end
        chk("to_trap_latency", 32'(lat), 32'd16);
        chk("to_req_cycles", 32'(nreq), 32'd16);
        chk("to_req_after", 32'(imem_req), 32'd0);
        chk("to_state", 32'(state), 32'd7);

        // ---- decode traps ----
        do_reset();
        fetch(OH_TWO);
        chk("two_bits_decode", 32'(state), 32'd1);
        tick();
        chk("two_bits_trap", 32'({trap, state}), 32'b1_111);
        do_reset();
        fetch(OH_ILL);
        tick();
        chk("illegal_trap", 32'({trap, state}), 32'b1_111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
